// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad row scanner with per-key debounce and event FIFO
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   scan_en       1 = scanning active; 0 parks the scanner with rows released
//   col[3:0]      column inputs, 1 = key closed on the currently driven row
//   row[3:0]      one-hot row drive, 0 while idle
//   key_state     debounced key map, bit 4*row_index + col_bit
//   evt_valid     event FIFO head valid
//   evt_ready     consumer accepts the head
//   evt_code      {press=1/release=0, key[3:0]}
//   evt_overflow  sticky flag: an event was dropped on a full FIFO
//   overflow_clr  clears evt_overflow (a same-cycle overflow wins)

module keypad_scan_ctrl #(
    parameter int SCAN_DIV   = 25000,
    parameter int DEB_SCANS  = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_en,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [15:0] key_state,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [4:0]  evt_code,
    output logic        evt_overflow,
    input  logic        overflow_clr
);

    localparam int CW   = $clog2(SCAN_DIV);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    typedef enum logic {S_IDLE, S_DRIVE} state_t;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  dwell_cnt;
    logic [1:0]     row_idx;
    logic           sample;
    logic [15:0]    raw;
    logic           scan_complete;

    logic [3:0]     deb_cnt [16];
    logic [15:0]    flip;
    logic           eval_active;
    logic [3:0]     eval_idx;
    logic           push;
    logic [4:0]     push_code;

    logic [4:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  rd_ptr_next;
    logic [CNTW-1:0] fifo_cnt;
    logic [CNTW-1:0] cnt_after_pop;
    logic [CNTW-1:0] cnt_next;
    logic           pop;
    logic           push_ok;
    logic [4:0]     head_next;

    // Scan FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        row        = 4'b0000;
        sample     = 1'b0;
        case (state)
            S_IDLE: begin
                if (scan_en) begin
                    state_next = S_DRIVE;
                end
            end
            S_DRIVE: begin
                row = 4'b0001 << row_idx;
                if (!scan_en) begin
                    state_next = S_IDLE;
                end else if (dwell_cnt == CW'(SCAN_DIV - 1)) begin
                    sample = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Dwell counter and row index restart from row 0 whenever scanning is
    // not actively driving, so a re-enable always begins a fresh scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_cnt     <= '0;
            row_idx       <= 2'd0;
            raw           <= 16'h0000;
            scan_complete <= 1'b0;
        end else begin
            scan_complete <= sample && (row_idx == 2'd3);
            if (state != S_DRIVE || !scan_en) begin
                dwell_cnt <= '0;
                row_idx   <= 2'd0;
            end else if (sample) begin
                dwell_cnt                <= '0;
                row_idx                  <= row_idx + 2'd1;
                raw[4*row_idx +: 4]      <= col;
            end else begin
                dwell_cnt <= dwell_cnt + CW'(1);
            end
        end
    end

    // Debounce: a key must disagree with its stable state for DEB_SCANS
    // consecutive scans before it flips. flip[] marks keys awaiting an event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_state <= 16'h0000;
            flip      <= 16'h0000;
            for (int k = 0; k < 16; k++) begin
                deb_cnt[k] <= 4'd0;
            end
        end else begin
            if (push) begin
                flip[eval_idx] <= 1'b0;
            end
            if (scan_complete) begin
                for (int k = 0; k < 16; k++) begin
                    if (raw[k] == key_state[k]) begin
                        deb_cnt[k] <= 4'd0;
                    end else if (deb_cnt[k] == 4'(DEB_SCANS - 1)) begin
                        key_state[k] <= ~key_state[k];
                        deb_cnt[k]   <= 4'd0;
                        flip[k]      <= 1'b1;
                    end else begin
                        deb_cnt[k] <= deb_cnt[k] + 4'd1;
                    end
                end
            end
        end
    end

    // EVAL walks keys 0..15, one per cycle, so events leave in key order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eval_active <= 1'b0;
            eval_idx    <= 4'd0;
        end else if (scan_complete) begin
            eval_active <= 1'b1;
            eval_idx    <= 4'd0;
        end else if (eval_active) begin
            eval_idx <= eval_idx + 4'd1;
            if (eval_idx == 4'd15) begin
                eval_active <= 1'b0;
            end
        end
    end

    assign push      = eval_active && flip[eval_idx];
    assign push_code = {key_state[eval_idx], eval_idx};

    // Event FIFO. evt_valid/evt_code are registered copies of the head as it
    // will be after this cycle's push/pop; a push into a FIFO that is empty
    // after the pop bypasses memory straight into the head register.
    assign pop           = evt_valid && evt_ready;
    assign push_ok       = push && ((fifo_cnt != CNTW'(FIFO_DEPTH)) || pop);
    assign cnt_after_pop = fifo_cnt - CNTW'(pop);
    assign cnt_next      = cnt_after_pop + CNTW'(push_ok);
    assign rd_ptr_next   = rd_ptr + AW'(pop);
    assign head_next     = (cnt_after_pop == '0) ? push_code : mem[rd_ptr_next];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            evt_valid    <= 1'b0;
            evt_code     <= 5'd0;
            evt_overflow <= 1'b0;
        end else begin
            rd_ptr    <= rd_ptr_next;
            fifo_cnt  <= cnt_next;
            evt_valid <= (cnt_next != '0);
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (cnt_next != '0) begin
                evt_code <= head_next;
            end
            if (push && !push_ok) begin
                evt_overflow <= 1'b1;
            end else if (overflow_clr) begin
                evt_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - scoreboard bench for keypad_scan_ctrl

module tb_keypad_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        scan_en;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] key_state;
    logic        evt_valid;
    logic        evt_ready;
    logic [4:0]  evt_code;
    logic        evt_overflow;
    logic        overflow_clr;

    logic [15:0] key_mask;
    logic [4:0]  exp_q [$];
    int          n_checks;
    int          n_fail;

    keypad_scan_ctrl #(
        .SCAN_DIV   (8),
        .DEB_SCANS  (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .scan_en      (scan_en),
        .col          (col),
        .row          (row),
        .key_state    (key_state),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_overflow (evt_overflow),
        .overflow_clr (overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix model: a closed key shows on its column while its row is driven.
    always_comb begin
        case (row)
            4'b0001: col = key_mask[3:0];
            4'b0010: col = key_mask[7:4];
            4'b0100: col = key_mask[11:8];
            4'b1000: col = key_mask[15:12];
            default: col = 4'b0000;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns at the negedge of the scan_complete cycle (row just wrapped 1000 -> 0001).
    task automatic wait_scan();
        logic [3:0] last;
        int         n;
        bit         done;
        last = row;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            n++;
            if (last == 4'b1000 && row == 4'b0001) begin
                done = 1'b1;
            end else if (n > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL scan_timeout: got no scan wrap expected wrap within 200 cycles");
                done = 1'b1;
            end
            last = row;
        end
    endtask

    task automatic wait_scans(input int n);
        for (int i = 0; i < n; i++) begin
            wait_scan();
        end
    endtask

    // Monitor: every accepted event is compared against the scoreboard head.
    initial begin
        logic [4:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && evt_valid && evt_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL evt_unexpected: got 0x%0h expected no event at %0t", evt_code, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (evt_code !== e) begin
                        n_fail++;
                        $display("FAIL evt_code: got 0x%0h expected 0x%0h at %0t", evt_code, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0] er;
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        scan_en      = 1'b0;
        evt_ready    = 1'b1;
        overflow_clr = 1'b0;
        key_mask     = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: reset state and row sequencing
        check("reset_row", 32'(row), 32'h0);
        check("reset_evt_valid", 32'(evt_valid), 32'h0);
        check("reset_key_state", 32'(key_state), 32'h0);
        check("reset_overflow", 32'(evt_overflow), 32'h0);
        check("reset_evt_code", 32'(evt_code), 32'h0);
        scan_en = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            er = 4'b0001 << (((i - 1) / 8) % 4);
            check("row_seq", 32'(row), 32'(er));
        end

        // 2: key 5 press and release
        wait_scan();
        key_mask = 16'h0020;
        wait_scans(2);
        check("press_not_yet", 32'(key_state), 32'h0);
        wait_scan();
        exp_q.push_back(5'b1_0101);
        @(negedge clk);
        check("press_key_state", 32'(key_state), 32'h0020);
        key_mask = 16'h0000;
        wait_scans(3);
        exp_q.push_back(5'b0_0101);
        @(negedge clk);
        check("release_key_state", 32'(key_state), 32'h0);
        repeat (20) @(negedge clk);
        check("t2_queue_drained", 32'(exp_q.size()), 32'h0);

        // 3: short press never flips; counter restarts after release
        wait_scan();
        key_mask = 16'h0020;
        wait_scans(2);
        key_mask = 16'h0000;
        wait_scan();
        key_mask = 16'h0020;
        wait_scans(2);
        key_mask = 16'h0000;
        wait_scans(2);
        repeat (20) @(negedge clk);
        check("bounce_key_state", 32'(key_state), 32'h0);
        check("bounce_no_evt", 32'(evt_valid), 32'h0);

        // 4: overflow with consumer stalled, then clear and drain
        evt_ready = 1'b0;
        wait_scan();
        key_mask = 16'h003F;
        wait_scans(3);
        exp_q.push_back(5'b1_0000);
        exp_q.push_back(5'b1_0001);
        exp_q.push_back(5'b1_0010);
        exp_q.push_back(5'b1_0011);
        @(negedge clk);
        check("t4_key_state", 32'(key_state), 32'h003F);
        check("t4_latency_early", 32'(evt_valid), 32'h0);
        @(negedge clk);
        check("t4_latency_k0", 32'(evt_valid), 32'h1);
        check("t4_head_code", 32'(evt_code), 32'h10);
        repeat (20) @(negedge clk);
        check("t4_overflow_set", 32'(evt_overflow), 32'h1);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        check("t4_overflow_clr", 32'(evt_overflow), 32'h0);
        evt_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("t4_drained_valid", 32'(evt_valid), 32'h0);
        check("t4_queue_drained", 32'(exp_q.size()), 32'h0);

        // 5: scan_en drop mid-scan keeps debounce progress
        wait_scan();
        key_mask = 16'h0000;
        wait_scan();
        repeat (16) @(negedge clk);
        check("t5_row_before_drop", 32'(row), 32'h4);
        scan_en = 1'b0;
        @(negedge clk);
        check("t5_row_idle", 32'(row), 32'h0);
        repeat (3) @(negedge clk);
        scan_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t5_row_restart", 32'(row), 32'h1);
        end
        @(negedge clk);
        check("t5_row_next", 32'(row), 32'h2);
        wait_scan();
        @(negedge clk);
        check("t5_progress_hold", 32'(key_state), 32'h003F);
        wait_scan();
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(5'(k));
        end
        @(negedge clk);
        check("t5_release_all", 32'(key_state), 32'h0);
        repeat (20) @(negedge clk);
        check("t5_queue_drained", 32'(exp_q.size()), 32'h0);

        // 6: asynchronous reset during EVAL with events queued
        evt_ready = 1'b0;
        wait_scan();
        key_mask = 16'h0003;
        wait_scans(3);
        repeat (4) @(negedge clk);
        check("t6_pre_valid", 32'(evt_valid), 32'h1);
        check("t6_pre_key_state", 32'(key_state), 32'h0003);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(evt_valid), 32'h0);
        check("t6_rst_row", 32'(row), 32'h0);
        check("t6_rst_key_state", 32'(key_state), 32'h0);
        check("t6_rst_evt_code", 32'(evt_code), 32'h0);
        exp_q.delete();
        scan_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_post_overflow", 32'(evt_overflow), 32'h0);
        check("t6_post_row", 32'(row), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Controller that sequences the 4x4 keypad matrix. It drives the one-hot row lines with a programmable dwell and samples the column inputs at the end of each dwell. Each key is debounced across whole-matrix scans, and every press or release becomes an event in a small FIFO. The CPU-side display/IO logic drains the FIFO through a valid/ready handshake, and can also read the debounced 16-bit key state directly.

Parameters:
SCAN_DIV, 25000, clk cycles per row dwell; must be >= 5.
DEB_SCANS, 3, consecutive full scans a key must differ from its stable state before it flips; range 1..15.
FIFO_DEPTH, 8, event FIFO entries; power of two, >= 2.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
scan_en  in  1  1 = scanning active
col  in  4  column inputs, active-high (1 = key closed on driven row)
row  out  4  one-hot row drive; 0 when idle
key_state  out  16  debounced state; bit = 4*row_index + col_bit
evt_valid  out  1  FIFO head valid
evt_ready  in  1  consumer accepts head
evt_code  out  5  {press(1)/release(0), key[3:0]}
evt_overflow  out  1  sticky: an event was dropped
overflow_clr  in  1  clears evt_overflow

Behaviour:
- Reset (async, immediate): row=0, key_state=0, evt_valid=0, evt_code=0, evt_overflow=0. Dwell counter, row index, debounce counters and FIFO pointers are all cleared.
- Scan FSM: IDLE -> DRIVE.
  - IDLE: row=0. Entered on scan_en=0, from either state, on the next clk.
  - DRIVE: row = 1<<row_idx. The dwell counter runs 0..SCAN_DIV-1.
  - At count SCAN_DIV-1, col is registered into raw[4*row_idx+3 : 4*row_idx].
  - row_idx then wraps 3->0, giving the row sequence 0001,0010,0100,1000,0001. Each row is driven for exactly SCAN_DIV cycles.
- scan_complete: 1-cycle pulse in the cycle after row 3 is sampled.
- scan_en drop mid-scan: the partial raw vector is discarded, and no scan_complete is issued for that scan. key_state, debounce counters and FIFO all hold.
- Re-enable: starts at row 0001 with count 0.
- Debounce: on scan_complete, each key k is evaluated.
  - raw[k] == key_state[k]: cnt[k] <= 0.
  - raw[k] != key_state[k] and cnt[k] == DEB_SCANS-1: key_state[k] toggles, cnt[k] <= 0, flip[k] <= 1.
  - Otherwise: cnt[k] increments.
- EVAL: starts the cycle after scan_complete and lasts 16 cycles.
  - Key k is examined in cycle k (k = 0..15).
  - If flip[k] is set, an event {key_state[k], k} is pushed and flip[k] is cleared.
  - Events are therefore ordered by ascending key index within one scan.
  - SCAN_DIV >= 5 guarantees EVAL finishes before the next scan_complete.
- FIFO:
  - First-word fall-through: evt_valid/evt_code are registered and reflect the head one cycle after a push into an empty FIFO.
  - Pop on evt_valid && evt_ready.
  - Push while full: the event is dropped and evt_overflow <= 1; key_state still updates.
  - Push while full with a pop in the same cycle: push accepted, no overflow.
  - Push and pop on a non-empty, non-full FIFO: count unchanged.
  - evt_code holds its last value when evt_valid=0.
- evt_overflow: overflow_clr clears it. If overflow_clr and a new overflow occur in the same cycle, the set wins.
- Latency: a key held stable from scan n is reflected in key_state at the scan_complete of scan n+DEB_SCANS-1. Its event is visible on evt_valid k+2 cycles after that scan_complete.

Test Plan:
(Bench parameters: SCAN_DIV=8, DEB_SCANS=3, FIFO_DEPTH=4.)
1. Reset, scan_en=0 -> row=0, evt_valid=0. Set scan_en=1 -> row cycles 0001/0010/0100/1000, each for exactly 8 clk, period 32.
2. Drive col=0010 whenever row=0010 (key 5) for 3 full scans -> key_state=0x0020 at the 3rd scan_complete; one event 5'b1_0101. Release for 3 scans -> event 5'b0_0101, key_state=0.
3. Key 5 asserted for 2 scans, then released -> no event, key_state stays 0, cnt returns to 0.
4. evt_ready=0, keys 0..5 held for 3 scans -> FIFO holds 10000,10001,10010,10011; keys 4 and 5 dropped; evt_overflow=1; key_state=0x003F. Pulse overflow_clr -> evt_overflow=0. Set evt_ready=1 -> the 4 codes drain in order.
5. Drop scan_en while row=0100 -> row=0 next clk. Re-enable -> row=0001 for a full 8 cycles; debounce progress retained.
6. Assert rst mid-EVAL with 2 events queued -> evt_valid, row and key_state go to 0 immediately, before the next clk edge.
